// File: rtl/bcd_sub_serial_pkg.sv
// Shared definitions for the digit-serial BCD subtractor: FSM state encoding and BCD constants.
package bcd_sub_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [4:0] BCD_BASE = 5'd10;

endpackage

// File: rtl/bcd_digit_sub.sv
// One BCD digit of x - y - bi with ten's-complement correction and borrow-out.
module bcd_digit_sub
    import bcd_sub_serial_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       bi,
    output logic [3:0] d,
    output logic       bo,
    output logic       bad
);

    logic signed [4:0] t;

    always_comb begin
        t   = $signed({1'b0, x}) - $signed({1'b0, y}) - $signed({4'b0000, bi});
        bo  = t[4];
        // The true digit is 0..9, so adding the base modulo 16 lands on it directly.
        d   = t[3:0] + (bo ? BCD_BASE[3:0] : 4'd0);
        bad = (x > BCD_MAX) || (y > BCD_MAX);
    end

endmodule

// File: rtl/bcd_sub_serial.sv
// Digit-serial BCD subtractor: A - B - bin, one digit per clock, least significant digit first.
module bcd_sub_serial
    import bcd_sub_serial_pkg::*;
#(
    parameter int NDIG = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [4*NDIG-1:0] a,
    input  logic [4*NDIG-1:0] b,
    input  logic              bin,
    output logic [4*NDIG-1:0] diff,
    output logic              bout,
    output logic              busy,
    output logic              done,
    output logic              invalid
);

    localparam int             IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IW-1:0]  LAST = IW'(NDIG - 1);

    state_t            state;
    state_t            state_next;
    logic [4*NDIG-1:0] a_sh;
    logic [4*NDIG-1:0] b_sh;
    logic [4*NDIG-1:0] diff_r;
    logic [IW-1:0]     idx;
    logic              borrow;
    logic              invalid_r;
    logic              bout_r;
    logic              invalid_out;
    logic              in_bad;
    logic              last;
    logic [3:0]        dig;
    logic              dig_bo;
    logic              dig_bad;

    assign last = (idx == LAST);

    always_comb begin
        in_bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if ((a[4*i +: 4] > BCD_MAX) || (b[4*i +: 4] > BCD_MAX)) begin
                in_bad = 1'b1;
            end
        end
    end

    bcd_digit_sub u_digit (
        .x   (a_sh[3:0]),
        .y   (b_sh[3:0]),
        .bi  (borrow),
        .d   (dig),
        .bo  (dig_bo),
        .bad (dig_bad)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CALC) || (state == DONE);
        done = (state == DONE);
    end

    assign diff    = diff_r;
    assign bout    = bout_r;
    assign invalid = invalid_out;

    // Operands shift right so the active digit is always in [3:0]; results land at diff[idx].
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_sh        <= '0;
            b_sh        <= '0;
            diff_r      <= '0;
            idx         <= '0;
            borrow      <= 1'b0;
            invalid_r   <= 1'b0;
            bout_r      <= 1'b0;
            invalid_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh        <= a;
                        b_sh        <= b;
                        borrow      <= bin;
                        idx         <= '0;
                        invalid_r   <= in_bad;
                        diff_r      <= '0;
                        bout_r      <= 1'b0;
                        invalid_out <= 1'b0;
                    end
                end
                CALC: begin
                    a_sh                     <= a_sh >> 4;
                    b_sh                     <= b_sh >> 4;
                    borrow                   <= dig_bo;
                    idx                      <= idx + 1'b1;
                    diff_r[4*int'(idx) +: 4] <= dig;
                    if (last) begin
                        if (invalid_r || dig_bad) begin
                            diff_r      <= '0;
                            bout_r      <= 1'b0;
                            invalid_out <= 1'b1;
                        end else begin
                            bout_r <= dig_bo;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_sub_serial.sv
// Bench for bcd_sub_serial: decimal-arithmetic reference model plus directed literal vectors.
module tb_bcd_sub_serial;

    localparam int NDIG = 2;
    localparam int W    = 4 * NDIG;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         bin   = 1'b0;
    logic [W-1:0] diff;
    logic         bout;
    logic         busy;
    logic         done;
    logic         invalid;

    int n_tests = 0;
    int n_fail  = 0;
    bit checking = 0;

    bcd_sub_serial #(.NDIG(NDIG)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .bin     (bin),
        .diff    (diff),
        .bout    (bout),
        .busy    (busy),
        .done    (done),
        .invalid (invalid)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference: convert to integers, subtract, wrap negatives by 10^NDIG, convert back.
    function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                                  output logic [W-1:0] d, output logic bo, output logic iv);
        int va = 0;
        int vb = 0;
        int r;
        int base = 1;
        iv = 1'b0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            if (av[4*i +: 4] > 9 || bv[4*i +: 4] > 9) iv = 1'b1;
            va = va * 10 + int'(av[4*i +: 4]);
            vb = vb * 10 + int'(bv[4*i +: 4]);
            base = base * 10;
        end
        r  = va - vb - int'(bi);
        bo = (r < 0);
        if (bo) r = r + base;
        d = '0;
        for (int i = 0; i < NDIG; i++) begin
            d[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        if (iv) begin
            d  = '0;
            bo = 1'b0;
        end
    endfunction

    // Model timeline: 0 = idle, 1..NDIG = digit cycles, NDIG+1 = result cycle.
    int           m_cnt = 0;
    logic [W-1:0] m_diff = '0, p_diff;
    logic         m_bout = 1'b0, m_inv = 1'b0, p_bout, p_inv;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_cnt  = 0;
            m_diff = '0;
            m_bout = 1'b0;
            m_inv  = 1'b0;
        end else if (m_cnt == 0) begin
            if (start) begin
                model(a, b, bin, p_diff, p_bout, p_inv);
                m_diff = '0;
                m_bout = 1'b0;
                m_inv  = 1'b0;
                m_cnt  = 1;
            end
        end else if (m_cnt == NDIG + 1) begin
            m_cnt = 0;
        end else begin
            m_cnt++;
            if (m_cnt == NDIG + 1) begin
                m_diff = p_diff;
                m_bout = p_bout;
                m_inv  = p_inv;
            end
        end
    end

    always @(negedge clock) begin
        if (checking) begin
            chk("busy", 32'(busy), 32'(m_cnt != 0));
            chk("done", 32'(done), 32'(m_cnt == NDIG + 1));
            if (m_cnt == 0 || m_cnt == NDIG + 1) begin
                chk("diff", 32'(diff), 32'(m_diff));
                chk("bout", 32'(bout), 32'(m_bout));
                chk("invalid", 32'(invalid), 32'(m_inv));
            end
        end
    end

    task automatic op(input string nm, input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                      input logic [W-1:0] ed, input logic eb, input logic ei);
        int n;
        @(negedge clock);
        a = av; b = bv; bin = bi; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 1;
        while (!done && n < 10) begin
            @(negedge clock);
            n++;
        end
        chk({nm, "_latency"}, 32'(n), 32'(NDIG + 1));
        chk({nm, "_diff"}, 32'(diff), 32'(ed));
        chk({nm, "_bout"}, 32'(bout), 32'(eb));
        chk({nm, "_invalid"}, 32'(invalid), 32'(ei));
    endtask

    initial begin
        logic [W-1:0] md;
        logic         mb, mi;
        int           n_done;

        model(8'h45, 8'h23, 1'b0, md, mb, mi);
        chk("model_45_23", 32'({md, mb, mi}), 32'({8'h22, 1'b0, 1'b0}));
        model(8'h00, 8'h00, 1'b1, md, mb, mi);
        chk("model_00_00_b1", 32'({md, mb, mi}), 32'({8'h99, 1'b1, 1'b0}));
        model(8'h4A, 8'h11, 1'b0, md, mb, mi);
        chk("model_bad", 32'({md, mb, mi}), 32'({8'h00, 1'b0, 1'b1}));

        repeat (3) @(negedge clock);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'({diff, bout, invalid}), 32'd0);
        checking = 1;
        reset = 1'b1;

        op("sub_45_23", 8'h45, 8'h23, 1'b0, 8'h22, 1'b0, 1'b0);
        op("sub_23_45", 8'h23, 8'h45, 1'b0, 8'h78, 1'b1, 1'b0);
        op("sub_00_00_b1", 8'h00, 8'h00, 1'b1, 8'h99, 1'b1, 1'b0);
        op("sub_90_09", 8'h90, 8'h09, 1'b0, 8'h81, 1'b0, 1'b0);
        op("sub_4A_11", 8'h4A, 8'h11, 1'b0, 8'h00, 1'b0, 1'b1);
        op("sub_50_25", 8'h50, 8'h25, 1'b0, 8'h25, 1'b0, 1'b0);
        op("sub_99_99", 8'h99, 8'h99, 1'b0, 8'h00, 1'b0, 1'b0);
        op("sub_00_01", 8'h00, 8'h01, 1'b0, 8'h99, 1'b1, 1'b0);
        op("sub_10_01_b1", 8'h10, 8'h01, 1'b1, 8'h08, 1'b0, 1'b0);

        // start held high: one acceptance per IDLE visit; operand changes while busy are ignored.
        @(negedge clock);
        a = 8'h45; b = 8'h23; bin = 1'b0; start = 1'b1;
        n_done = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (k == 1) begin
                a = 8'h12; b = 8'h34;
            end
            if (done) begin
                n_done++;
                if (n_done == 1) chk("held_first_diff", 32'(diff), 32'h22);
                if (n_done == 2) chk("held_second_diff", 32'({diff, bout}), 32'({8'h78, 1'b1}));
            end
            if (k == 8) start = 1'b0;
        end
        chk("held_done_count", 32'(n_done), 32'd2);

        // Reset mid-operation.
        @(negedge clock);
        a = 8'h45; b = 8'h23; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_diff", 32'(diff), 32'd0);
        chk("midrst_flags", 32'({bout, invalid}), 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        n_done = 0;
        repeat (6) begin
            @(negedge clock);
            if (done) n_done++;
        end
        chk("no_done_after_reset", 32'(n_done), 32'd0);
        op("after_rst_50_25", 8'h50, 8'h25, 1'b0, 8'h25, 1'b0, 1'b0);

        repeat (2) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
